// File: rtl/tdm_demux.sv
// tdm_demux: double-buffered TDM byte-stream demultiplexer into NCH channel registers.
// Optional inter-beat gap timeout enabled by defining TDM_DEMUX_TIMEOUT_EN.
module tdm_demux #(
    parameter int NCH     = 4,
    parameter int W       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic                    in_sof,
    input  logic [W-1:0]            in_data,
    output logic [NCH*W-1:0]        out_data,
    output logic                    out_valid,
    output logic                    frame_err,
    output logic [7:0]              err_cnt,
    output logic [$clog2(NCH)-1:0]  ch_idx
);
    localparam int CW = $clog2(NCH);
    typedef enum logic {IDLE, COLLECT} state_t;
    state_t                  state_q, state_d;
    logic [CW-1:0]           ch_idx_q, ch_idx_d;
    logic [NCH-1:0][W-1:0]   shadow_q, shadow_d;
    logic [NCH*W-1:0]        out_data_q, out_data_d;
    logic                    out_valid_q, out_valid_d;
    logic                    frame_err_q, frame_err_d;
    logic [7:0]              err_cnt_q, err_cnt_d;
`ifdef TDM_DEMUX_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT + 1);
    logic [GW-1:0]           gap_q, gap_d;
`endif

    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        shadow_d    = shadow_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        frame_err_d = 1'b0;
`ifdef TDM_DEMUX_TIMEOUT_EN
        gap_d       = '0;
`endif
        if (in_valid && in_sof) begin
            // An sof always restarts the frame; inside COLLECT it also flags the loss
            shadow_d[0] = in_data;
            ch_idx_d    = CW'(1);
            state_d     = COLLECT;
            frame_err_d = (state_q == COLLECT);
        end else if (in_valid && state_q == COLLECT) begin
            shadow_d[ch_idx_q] = in_data;
            if (ch_idx_q == CW'(NCH - 1)) begin
                out_data_d  = shadow_d;
                out_valid_d = 1'b1;
                ch_idx_d    = '0;
                state_d     = IDLE;
            end else begin
                ch_idx_d = ch_idx_q + CW'(1);
            end
        end
`ifdef TDM_DEMUX_TIMEOUT_EN
        else if (!in_valid && state_q == COLLECT) begin
            gap_d = gap_q + GW'(1);
            if (gap_d == GW'(TIMEOUT)) begin
                frame_err_d = 1'b1;
                ch_idx_d    = '0;
                state_d     = IDLE;
                gap_d       = '0;
            end
        end
`endif
        err_cnt_d = err_cnt_q + 8'((frame_err_d && err_cnt_q != 8'hFF) ? 1 : 0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            ch_idx_q    <= '0;
            shadow_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            err_cnt_q   <= '0;
`ifdef TDM_DEMUX_TIMEOUT_EN
            gap_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ch_idx_q    <= ch_idx_d;
            shadow_q    <= shadow_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            frame_err_q <= frame_err_d;
            err_cnt_q   <= err_cnt_d;
`ifdef TDM_DEMUX_TIMEOUT_EN
            gap_q       <= gap_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign frame_err = frame_err_q;
    assign err_cnt   = err_cnt_q;
    assign ch_idx    = ch_idx_q;
endmodule

// File: tb/tb_tdm_demux.sv
// tb_tdm_demux: scoreboard bench for tdm_demux (NCH=4, W=8, TIMEOUT=16).
module tb_tdm_demux;
    localparam int NCH = 4;
    localparam int W   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_sof = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic [NCH*W-1:0] out_data;
    logic             out_valid;
    logic             frame_err;
    logic [7:0]       err_cnt;
    logic [1:0]       ch_idx;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int err_pulses = 0;
    int valid_pulses = 0;
    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];
    int          got_t[$];

    tdm_demux #(.NCH(NCH), .W(W), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof),
        .in_data(in_data), .out_data(out_data), .out_valid(out_valid),
        .frame_err(frame_err), .err_cnt(err_cnt), .ch_idx(ch_idx)
    );

    always #5 clk = ~clk;

    // Outputs are captured on the falling edge, half a cycle away from updates
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (out_valid) begin
            got_q.push_back(out_data);
            got_t.push_back(cyc);
            valid_pulses <= valid_pulses + 1;
        end
        if (frame_err) err_pulses <= err_pulses + 1;
    end

    task automatic send(input logic sof, input logic [7:0] d);
        @(negedge clk);
        in_valid = 1'b1;
        in_sof   = sof;
        in_data  = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            in_sof   = 1'b0;
        end
    endtask

    task automatic send_frame(input logic [31:0] f, input int gap);
        exp_q.push_back(f);
        for (int k = 0; k < NCH; k++) begin
            send(k == 0, f[k*8 +: 8]);
            if (gap > 0 && k < NCH - 1) idle(gap);
        end
    endtask

    function automatic void pop(output logic [31:0] e, output logic [31:0] g, output bit ok);
        e  = exp_q.size() ? exp_q.pop_front() : 32'hx;
        ok = got_q.size() != 0;
        g  = ok ? got_q.pop_front() : 32'hx;
        if (got_t.size()) void'(got_t.pop_front());
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        rst_n = 1'b1;
        checks += 5;
        if (out_data !== 32'h0) begin failures++; $display("FAIL reset_out_data got=%h want=0", out_data); end
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b want=0", frame_err); end
        if (err_cnt !== 8'd0) begin failures++; $display("FAIL reset_err_cnt got=%0d want=0", err_cnt); end
        if (ch_idx !== 2'd0) begin failures++; $display("FAIL reset_ch_idx got=%0d want=0", ch_idx); end
    endtask

    task automatic test_basic();
        logic [31:0] e, g;
        bit ok;
        send_frame(32'h44332211, 0);
        idle(1);
        checks += 3;
        if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_latency out_valid=%b want=1", out_valid); end
        if (out_data !== 32'h44332211) begin failures++; $display("FAIL basic_data_now got=%h want=44332211", out_data); end
        idle(1);
        if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_pulse_width out_valid=%b want=0", out_valid); end
        idle(2);
        pop(e, g, ok);
        checks += 2;
        if (!ok || g !== e) begin failures++; $display("FAIL basic_frame got=%h want=%h", g, e); end
        if (err_cnt !== 8'd0) begin failures++; $display("FAIL basic_err_cnt got=%0d want=0", err_cnt); end
    endtask

    task automatic test_drop();
        logic [31:0] e, g;
        bit ok;
        int ep = err_pulses;
        send(1'b0, 8'hAA);
        send(1'b0, 8'hBB);
        send_frame(32'h04030201, 0);
        idle(3);
        pop(e, g, ok);
        checks += 3;
        if (!ok || g !== e) begin failures++; $display("FAIL drop_frame got=%h want=%h", g, e); end
        if (err_pulses != ep) begin failures++; $display("FAIL drop_no_err pulses=%0d want=%0d", err_pulses, ep); end
        if (ch_idx !== 2'd0) begin failures++; $display("FAIL drop_ch_idx got=%0d want=0", ch_idx); end
    endtask

    task automatic test_early_sof();
        logic [31:0] e, g;
        bit ok;
        send(1'b1, 8'h10);
        send(1'b0, 8'h20);
        exp_q.push_back(32'h80706050);
        send(1'b1, 8'h50);
        send(1'b0, 8'h60);
        checks += 3;
        if (frame_err !== 1'b1) begin failures++; $display("FAIL early_sof_err got=%b want=1", frame_err); end
        if (err_cnt !== 8'd1) begin failures++; $display("FAIL early_sof_cnt got=%0d want=1", err_cnt); end
        if (out_data !== 32'h04030201) begin failures++; $display("FAIL early_sof_hold got=%h want=04030201", out_data); end
        send(1'b0, 8'h70);
        send(1'b0, 8'h80);
        idle(3);
        pop(e, g, ok);
        checks += 2;
        if (!ok || g !== e) begin failures++; $display("FAIL early_sof_frame got=%h want=%h", g, e); end
        if (err_cnt !== 8'd1) begin failures++; $display("FAIL early_sof_cnt_after got=%0d want=1", err_cnt); end
    endtask

    task automatic test_gaps();
        logic [31:0] e, g;
        bit ok;
        int vp = valid_pulses;
        send_frame(32'hEFBEADDE, 3);
        idle(4);
        pop(e, g, ok);
        checks += 2;
        if (!ok || g !== e) begin failures++; $display("FAIL gaps_frame got=%h want=%h", g, e); end
        if (valid_pulses != vp + 1) begin failures++; $display("FAIL gaps_pulses got=%0d want=%0d", valid_pulses - vp, 1); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] e, g;
        bit ok;
        int t0;
        send_frame(32'hA3A2A1A0, 0);
        send_frame(32'hB3B2B1B0, 0);
        send(1'b1, 8'hC0);
        send(1'b0, 8'hC1);
        checks += 4;
        t0 = got_t.size() ? got_t[0] : -100;
        if (got_t.size() != 2 || got_t[1] - t0 != NCH) begin
            failures++; $display("FAIL b2b_spacing pulses=%0d want=2 spacing=%0d", got_t.size(), NCH);
        end
        pop(e, g, ok);
        if (!ok || g !== e) begin failures++; $display("FAIL b2b_frame0 got=%h want=%h", g, e); end
        pop(e, g, ok);
        if (!ok || g !== e) begin failures++; $display("FAIL b2b_frame1 got=%h want=%h", g, e); end
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        if (out_data !== 32'h0 || err_cnt !== 8'd0 || ch_idx !== 2'd0 || frame_err !== 1'b0) begin
            failures++; $display("FAIL b2b_reset data=%h cnt=%0d idx=%0d err=%b want 0/0/0/0", out_data, err_cnt, ch_idx, frame_err);
        end
        send_frame(32'hD3D2D1D0, 0);
        idle(3);
        pop(e, g, ok);
        checks += 2;
        if (!ok || g !== e) begin failures++; $display("FAIL b2b_after_reset got=%h want=%h", g, e); end
        if (err_pulses != 1) begin failures++; $display("FAIL b2b_err_pulses got=%0d want=1", err_pulses); end
    endtask

    task automatic test_timeout();
        logic [31:0] e, g;
        bit ok;
        int ep = err_pulses;
        send(1'b1, 8'h01);
        idle(18);
`ifdef TDM_DEMUX_TIMEOUT_EN
        checks += 3;
        if (err_pulses != ep + 1) begin failures++; $display("FAIL timeout_err got=%0d want=%0d", err_pulses - ep, 1); end
        if (err_cnt !== 8'd1) begin failures++; $display("FAIL timeout_cnt got=%0d want=1", err_cnt); end
        if (ch_idx !== 2'd0) begin failures++; $display("FAIL timeout_idle ch_idx=%0d want=0", ch_idx); end
`else
        checks += 1;
        if (ch_idx !== 2'd1) begin failures++; $display("FAIL wait_ch_idx got=%0d want=1", ch_idx); end
        exp_q.push_back(32'h04030201);
        send(1'b0, 8'h02);
        send(1'b0, 8'h03);
        send(1'b0, 8'h04);
        idle(3);
        pop(e, g, ok);
        checks += 2;
        if (!ok || g !== e) begin failures++; $display("FAIL wait_frame got=%h want=%h", g, e); end
        if (err_pulses != ep) begin failures++; $display("FAIL wait_no_err got=%0d want=0", err_pulses - ep); end
`endif
        checks += 1;
        if (got_q.size() != 0) begin failures++; $display("FAIL extra_frames got=%0d want=0", got_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_drop();
        test_early_sof();
        test_gaps();
        test_back_to_back();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
